// File: rtl/imem_boot_loader_if.sv
// Host byte link and instruction-memory write port of the boot loader.
// Handshake: a byte moves from host to loader on every rising clk edge where
// rx_valid && rx_ready are both 1. The host keeps rx_valid and rx_data steady
// until that edge. rx_ready never depends combinationally on rx_valid.
// imem_we is a one-cycle strobe that needs no acknowledge. imem_addr and
// imem_wdata are valid while imem_we is 1.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  core_hold, done, error, words_loaded, dbg_state
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output core_hold, done, error, words_loaded, dbg_state
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader. It takes a framed byte stream (A5, LEN_LO, LEN_HI, 4*LEN data
// bytes, CHK), builds little-endian words from the data bytes and writes them
// to instruction memory. The core stays in reset until the checksum matches.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 256,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    idx;
  logic [23:0]   word_lo;
  logic [7:0]    chk;
  logic [TW-1:0] tcnt;

  logic          accept;
  logic          timed_out;
  logic          in_frame;
  logic [15:0]   len_next;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CHECK);
  assign timed_out = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign len_next  = {bus.rx_data, len[7:0]};

  assign bus.dbg_state = state;

  // Frame sequencer. Every output is registered here along with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      len              <= '0;
      idx              <= '0;
      word_lo          <= '0;
      chk              <= '0;
      tcnt             <= '0;
      bus.rx_ready     <= 1'b1;
      bus.imem_we      <= 1'b0;
      bus.imem_addr    <= BASE_ADDR;
      bus.imem_wdata   <= '0;
      bus.core_hold    <= 1'b1;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (accept && bus.rx_data == 8'hA5) begin
            state            <= S_LEN_LO;
            chk              <= '0;
            bus.words_loaded <= '0;
            bus.error        <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.rx_data;
            chk      <= chk ^ bus.rx_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.rx_data;
            chk       <= chk ^ bus.rx_data;
            if (len_next == 16'd0 || len_next > 16'(MAX_WORDS)) begin
              state     <= S_ERROR;
              bus.error <= 1'b1;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            chk <= chk ^ bus.rx_data;
            idx <= idx + 2'd1;
            case (idx)
              2'd0: word_lo[7:0]   <= bus.rx_data;
              2'd1: word_lo[15:8]  <= bus.rx_data;
              2'd2: word_lo[23:16] <= bus.rx_data;
              default: begin
                // The last byte goes straight into the write data register.
                state          <= S_WRITE;
                bus.rx_ready   <= 1'b0;
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= BASE_ADDR + {14'd0, bus.words_loaded, 2'b00};
                bus.imem_wdata <= {bus.rx_data, word_lo};
              end
            endcase
          end
        end
        S_WRITE: begin
          bus.rx_ready     <= 1'b1;
          bus.imem_we      <= 1'b0;
          bus.words_loaded <= bus.words_loaded + 16'd1;
          if (bus.words_loaded + 16'd1 == len) state <= S_CHECK;
          else                                 state <= S_DATA;
        end
        S_CHECK: begin
          if (accept) begin
            if (bus.rx_data == chk) begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.core_hold <= 1'b0;
              bus.rx_ready  <= 1'b0;
            end else begin
              state     <= S_ERROR;
              bus.error <= 1'b1;
            end
          end
        end
        default: begin
          // S_DONE stays here until reset.
        end
      endcase

      // Inter-byte watchdog. It is cleared by any accepted byte and whenever
      // the sequencer is outside the frame body.
      if (in_frame && !accept) begin
        if (timed_out) begin
          state     <= S_ERROR;
          bus.error <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule
